// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage MIPS pipeline with ID-stage branch resolution.
// Tracks destination info for EX/MEM/WB and produces stalls, flushes, forwarding selects and pc_src.
module pipeline_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wr_en,
    input  logic [REG_W-1:0] id_wr_reg,
    input  logic             id_is_load,
    input  logic             id_is_branch,
    input  logic             id_is_jump,
    input  logic             id_br_cond,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic [1:0]       pc_src,
    output logic             fwd_a_d,
    output logic             fwd_b_d,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic             valid;
        logic             wr_en;
        logic             is_load;
        logic [REG_W-1:0] wr_reg;
    } dst_t;

    dst_t             ex_q,     ex_d;
    dst_t             mem_q;
    dst_t             wb_q;
    logic [REG_W-1:0] ex_rs_q,  ex_rs_d;
    logic [REG_W-1:0] ex_rt_q,  ex_rt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             stall;
    logic             flush;

    // Register 0 is hard-wired, so it never counts as a write target.
    function automatic logic writes(input dst_t s, input logic [REG_W-1:0] r);
        return s.valid && s.wr_en && (s.wr_reg == r) && (r != '0);
    endfunction

    // Per-operand hazard detection: index 0 is rs / operand A, index 1 is rt / operand B.
    logic [REG_W-1:0] id_src  [2];
    logic [REG_W-1:0] ex_src  [2];
    logic             id_use  [2];
    logic             lu_hit  [2];
    logic             br_hit  [2];
    logic             fwd_d   [2];
    logic [1:0]       fwd_e   [2];

    assign id_src[0] = id_rs;
    assign id_src[1] = id_rt;
    assign ex_src[0] = ex_rs_q;
    assign ex_src[1] = ex_rt_q;
    assign id_use[0] = id_use_rs;
    assign id_use[1] = id_use_rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            assign lu_hit[gi] = id_use[gi] && ex_q.is_load && writes(ex_q, id_src[gi]);
            assign br_hit[gi] = writes(ex_q, id_src[gi])
                              || (mem_q.is_load && writes(mem_q, id_src[gi]));
            assign fwd_d[gi]  = id_is_branch && !mem_q.is_load && writes(mem_q, id_src[gi]);
            assign fwd_e[gi]  = (!mem_q.is_load && writes(mem_q, ex_src[gi])) ? 2'b10 :
                                writes(wb_q, ex_src[gi])                       ? 2'b01 :
                                                                                 2'b00;
        end
    endgenerate

    always_comb begin
        stall = (id_valid && (lu_hit[0] || lu_hit[1]))
              || (id_is_branch && (br_hit[0] || br_hit[1]));
        flush = id_valid && !stall && (id_is_jump || (id_is_branch && id_br_cond));

        pc_src = 2'b00;
        if (id_valid && !stall) begin
            if (id_is_jump) begin
                pc_src = 2'b10;
            end else if (id_is_branch && id_br_cond) begin
                pc_src = 2'b01;
            end
        end
    end

    assign stall_f   = stall;
    assign stall_d   = stall;
    assign flush_e   = stall;
    assign flush_d   = flush;
    assign fwd_a_d   = fwd_d[0];
    assign fwd_b_d   = fwd_d[1];
    assign fwd_a_e   = fwd_e[0];
    assign fwd_b_e   = fwd_e[1];
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // A stalled or empty ID slot enters EX as an all-zero bubble.
    always_comb begin
        ex_d    = '0;
        ex_rs_d = '0;
        ex_rt_d = '0;
        if (id_valid && !stall) begin
            ex_d.valid   = 1'b1;
            ex_d.wr_en   = id_wr_en;
            ex_d.is_load = id_is_load;
            ex_d.wr_reg  = id_wr_reg;
            ex_rs_d      = id_rs;
            ex_rt_d      = id_rt;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed MIPS sequences plus random traffic against an instruction-history model.
module tb_pipeline_hazard_ctrl;

    localparam int RW = 5;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load;
    logic          id_is_branch, id_is_jump, id_br_cond;
    logic [RW-1:0] id_rs, id_rt, id_wr_reg;
    logic          stall_f, stall_d, flush_d, flush_e, fwd_a_d, fwd_b_d;
    logic [1:0]    pc_src, fwd_a_e, fwd_b_e;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.REG_W(RW), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
        .id_is_load(id_is_load), .id_is_branch(id_is_branch), .id_is_jump(id_is_jump),
        .id_br_cond(id_br_cond), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .flush_e(flush_e), .pc_src(pc_src), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Model: the last three instructions issued out of ID, newest first (0=EX, 1=MEM, 2=WB).
    typedef struct {
        bit       valid;
        bit       wr_en;
        bit       is_load;
        bit [4:0] dst;
        bit [4:0] rs;
        bit [4:0] rt;
    } instr_t;

    instr_t hist [3];
    int     m_stall_cnt, m_flush_cnt;

    function automatic bit produces(instr_t in, bit [4:0] r);
        return in.valid && in.wr_en && in.dst == r && r != 0;
    endfunction

    function automatic bit m_stall();
        bit lu, br;
        lu = id_valid && hist[0].is_load &&
             ((id_use_rs && produces(hist[0], id_rs)) || (id_use_rt && produces(hist[0], id_rt)));
        br = id_is_branch &&
             (produces(hist[0], id_rs) || produces(hist[0], id_rt) ||
              (hist[1].is_load && (produces(hist[1], id_rs) || produces(hist[1], id_rt))));
        return lu || br;
    endfunction

    function automatic bit [1:0] m_fwd_e(bit [4:0] r);
        if (produces(hist[1], r) && !hist[1].is_load) return 2'd2;
        if (produces(hist[2], r)) return 2'd1;
        return 2'd0;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit urs,
                         input bit urt, input bit we, input bit [4:0] wr, input bit ld,
                         input bit br, input bit jp, input bit cond);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_wr_en = we; id_wr_reg = wr; id_is_load = ld; id_is_branch = br;
        id_is_jump = jp; id_br_cond = cond;
        #1;
    endtask

    task automatic nop();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Compare all outputs with the model, then advance one clock and update the model.
    task automatic step();
        bit       s, f;
        bit [1:0] pc;
        s  = m_stall();
        f  = id_valid && !s && (id_is_jump || (id_is_branch && id_br_cond));
        pc = (!id_valid || s) ? 2'd0 : id_is_jump ? 2'd2 : (id_is_branch && id_br_cond) ? 2'd1 : 2'd0;
        chk("stall_f", stall_f, s);
        chk("stall_d", stall_d, s);
        chk("flush_e", flush_e, s);
        chk("flush_d", flush_d, f);
        chk("pc_src", pc_src, pc);
        chk("fwd_a_d", fwd_a_d, id_is_branch && !hist[1].is_load && produces(hist[1], id_rs));
        chk("fwd_b_d", fwd_b_d, id_is_branch && !hist[1].is_load && produces(hist[1], id_rt));
        chk("fwd_a_e", fwd_a_e, m_fwd_e(hist[0].rs));
        chk("fwd_b_e", fwd_b_e, m_fwd_e(hist[0].rt));
        chk("stall_cnt", stall_cnt, m_stall_cnt);
        chk("flush_cnt", flush_cnt, m_flush_cnt);
        @(posedge clock);
        if (reset) begin
            foreach (hist[i]) hist[i] = '{default: 0};
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = '{default: 0};
            if (id_valid && !s)
                hist[0] = '{valid: 1, wr_en: id_wr_en, is_load: id_is_load,
                            dst: id_wr_reg, rs: id_rs, rt: id_rt};
            if (s && m_stall_cnt < (1 << CW) - 1) m_stall_cnt++;
            if (f && m_flush_cnt < (1 << CW) - 1) m_flush_cnt++;
        end
        @(negedge clock);
    endtask

    initial begin
        foreach (hist[i]) hist[i] = '{default: 0};
        m_stall_cnt = 0;
        m_flush_cnt = 0;
        reset = 1'b1;
        nop();
        @(negedge clock);
        step();
        step();
        reset = 1'b0;
        nop();
        chk("rst_stall", stall_d, 0);
        chk("rst_pc", pc_src, 0);
        chk("rst_cnt", stall_cnt, 0);
        step();

        // lw gr1,1(gr0) ; add gr3,gr1,gr2
        apply(1, 0, 1, 1, 0, 1, 1, 1, 0, 0, 0); step();
        apply(1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0);
        chk("lu_stall_d", stall_d, 1); chk("lu_stall_f", stall_f, 1); chk("lu_flush_e", flush_e, 1);
        step();
        apply(1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0);
        chk("lu_release", stall_d, 0); chk("lu_cnt", stall_cnt, 1);
        step();
        nop(); chk("lu_fwd_wb", fwd_a_e, 2'b01); step();

        // add gr3,gr1,gr2 ; addi gr4,gr3,1 (back-to-back, then one NOP apart)
        apply(1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0); step();
        apply(1, 3, 4, 1, 0, 1, 4, 0, 0, 0, 0); chk("alu_nostall", stall_d, 0); step();
        nop(); chk("alu_fwd_mem", fwd_a_e, 2'b10); step();
        apply(1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0); step();
        nop(); step();
        apply(1, 3, 4, 1, 0, 1, 4, 0, 0, 0, 0); step();
        nop(); chk("alu_fwd_wb", fwd_a_e, 2'b01); step();

        // addi gr3,gr2,1 ; beq gr3,gr2
        apply(1, 2, 3, 1, 0, 1, 3, 0, 0, 0, 0); step();
        apply(1, 3, 2, 1, 1, 0, 0, 0, 1, 0, 0); chk("br_alu_stall", stall_d, 1); step();
        apply(1, 3, 2, 1, 1, 0, 0, 0, 1, 0, 0);
        chk("br_alu_go", stall_d, 0); chk("br_fwd_a_d", fwd_a_d, 1); step();
        // lw gr1 ; beq gr1,gr2 -> two stalls
        apply(1, 0, 1, 1, 0, 1, 1, 1, 0, 0, 0); step();
        apply(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0); chk("br_lw_st1", stall_d, 1); step();
        apply(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0); chk("br_lw_st2", stall_d, 1); step();
        apply(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0);
        chk("br_lw_go", stall_d, 0); chk("br_lw_nofwd", fwd_a_d, 0); chk("stall_cnt4", stall_cnt, 4);
        step();
        nop(); step(); nop(); step(); nop(); step();

        // taken beq, not-taken bne, jump
        apply(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 1);
        chk("beq_pc", pc_src, 2'b01); chk("beq_flush", flush_d, 1); step();
        nop(); chk("beq_fcnt", flush_cnt, 1); step();
        apply(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0);
        chk("bne_pc", pc_src, 0); chk("bne_flush", flush_d, 0); step();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("j_pc", pc_src, 2'b10); chk("j_flush", flush_d, 1); step();
        nop(); chk("j_once", flush_d, 0); chk("j_pc_after", pc_src, 0); chk("j_fcnt", flush_cnt, 2); step();

        // gr0 destinations never hazard
        apply(1, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0); step();
        apply(1, 0, 0, 1, 1, 1, 3, 0, 0, 0, 0); chk("gr0_nostall", stall_d, 0); step();
        nop(); chk("gr0_nofwd", fwd_a_e, 0); step();

        // reset in the middle of a load-use stall
        apply(1, 0, 5, 1, 0, 1, 5, 1, 0, 0, 0); step();
        apply(1, 5, 0, 1, 0, 1, 6, 0, 0, 0, 0); chk("rst_mid_stall", stall_d, 1);
        reset = 1'b1; step();
        nop();
        chk("rst_drop", stall_d, 0); chk("rst_fe", flush_e, 0);
        chk("rst_scnt", stall_cnt, 0); chk("rst_fcnt", flush_cnt, 0);
        step();
        reset = 1'b0;

        // saturation: repeated lw/use pairs
        for (int i = 0; i < (1 << CW) + 4; i++) begin
            apply(1, 0, 1, 1, 0, 1, 1, 1, 0, 0, 0); step();
            apply(1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0); step();
            apply(1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0); step();
        end
        nop(); chk("stall_sat", stall_cnt, (1 << CW) - 1); step();

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            bit v, br, jp, ld;
            int kind;
            v    = ($urandom_range(0, 9) < 8);
            kind = $urandom_range(0, 5);
            br   = v && kind == 0;
            jp   = v && kind == 1;
            ld   = v && kind == 2;
            reset = ($urandom_range(0, 299) == 0);
            apply(v, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  br || $urandom_range(0, 1) == 1, br || $urandom_range(0, 1) == 1,
                  ld || (!br && !jp && $urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                  ld, br, jp, 1'($urandom_range(0, 1)));
            step();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
